// File: rtl/mem_responder.sv
// 64-word register memory with a write-protected upper region. Each access is
// captured on one edge and answered (rvalid / wack / err) on the following edge.
module mem_responder #(
    parameter int unsigned DW      = 8,
    parameter logic [5:0]  RO_BASE = 6'd56
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          wr,
    input  logic [5:0]    addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          rvalid,
    output logic          wack,
    output logic          err,
    output logic [7:0]    wr_count,
    output logic [7:0]    rd_count
);

    logic [DW-1:0] mem_q [64];

    logic          rd_req;
    logic          wr_ok;
    logic          wr_rej;

    // Request stage: what was accepted at the last edge, answered at the next.
    logic          pend_rd_q;
    logic          pend_wok_q;
    logic          pend_rej_q;
    logic [DW-1:0] pend_data_q;

    logic [DW-1:0] rdata_q;
    logic [DW-1:0] rdata_d;
    logic          rvalid_q;
    logic          wack_q;
    logic          err_q;
    logic [7:0]    wr_count_q;
    logic [7:0]    wr_count_d;
    logic [7:0]    rd_count_q;
    logic [7:0]    rd_count_d;

    assign rd_req = en & ~wr;
    assign wr_ok  = en & wr & (addr < RO_BASE);
    assign wr_rej = en & wr & (addr >= RO_BASE);

    // Counters advance together with their response pulse, so a response
    // cancelled by reset is never counted.
    always_comb begin
        wr_count_d = wr_count_q;
        rd_count_d = rd_count_q;
        rdata_d    = rdata_q;
        if (pend_wok_q && (wr_count_q != 8'hFF)) begin
            wr_count_d = wr_count_q + 8'd1;
        end
        if (pend_rd_q && (rd_count_q != 8'hFF)) begin
            rd_count_d = rd_count_q + 8'd1;
        end
        if (pend_rd_q) begin
            rdata_d = pend_data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) begin
                mem_q[i] <= '0;
            end
            pend_rd_q   <= 1'b0;
            pend_wok_q  <= 1'b0;
            pend_rej_q  <= 1'b0;
            pend_data_q <= '0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            wack_q      <= 1'b0;
            err_q       <= 1'b0;
            wr_count_q  <= 8'd0;
            rd_count_q  <= 8'd0;
        end else begin
            if (wr_ok) begin
                mem_q[addr] <= wdata;
            end
            pend_rd_q  <= rd_req;
            pend_wok_q <= wr_ok;
            pend_rej_q <= wr_rej;
            if (rd_req) begin
                pend_data_q <= mem_q[addr];
            end
            rdata_q    <= rdata_d;
            rvalid_q   <= pend_rd_q;
            wack_q     <= pend_wok_q;
            err_q      <= pend_rej_q;
            wr_count_q <= wr_count_d;
            rd_count_q <= rd_count_d;
        end
    end

    assign rdata    = rdata_q;
    assign rvalid   = rvalid_q;
    assign wack     = wack_q;
    assign err      = err_q;
    assign wr_count = wr_count_q;
    assign rd_count = rd_count_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: the driver pushes expected responses into a
// queue and an independent monitor pops and compares them as the DUT pulses.
module tb_mem_responder;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          wr;
    logic [5:0]    addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          wack;
    logic          err;
    logic [7:0]    wr_count;
    logic [7:0]    rd_count;

    mem_responder #(.DW(DW), .RO_BASE(6'd56)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .wr       (wr),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .wack     (wack),
        .err      (err),
        .wr_count (wr_count),
        .rd_count (rd_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;   // 0 read, 1 write ack, 2 write error
        logic [7:0]  data;
        int          due;
    } exp_t;

    exp_t       sb[$];
    int         cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;
    bit         mon_on = 1'b0;
    logic [7:0] exp_last = 8'h00;
    logic [7:0] m_mem [64];
    int         m_wr = 0;
    int         m_rd = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 64; i++) m_mem[i] = 8'h00;
        m_wr = 0;
        m_rd = 0;
        sb.delete();
        exp_last = 8'h00;
    endfunction

    // Present one access now (caller is at a negedge) and record its expected response.
    task automatic drive(input logic w, input logic [5:0] a, input logic [7:0] d);
        exp_t e;
        en    = 1'b1;
        wr    = w;
        addr  = a;
        wdata = d;
        e.due = cyc + 2;
        if (!w) begin
            e.kind = 0;
            e.data = m_mem[a];
            if (m_rd < 255) m_rd++;
        end else if (a < 6'd56) begin
            e.kind = 1;
            e.data = 8'h00;
            m_mem[a] = d;
            if (m_wr < 255) m_wr++;
        end else begin
            e.kind = 2;
            e.data = 8'h00;
        end
        sb.push_back(e);
    endtask

    task automatic access(input logic w, input logic [5:0] a, input logic [7:0] d);
        @(negedge clk);
        drive(w, a, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            en    = 1'b0;
            wr    = 1'($urandom_range(0, 1));
            addr  = 6'($urandom_range(0, 63));
            wdata = 8'($urandom_range(0, 255));
        end
    endtask

    task automatic check_counts(input string tag);
        @(negedge clk);
        check({tag, "_wr_count"}, {24'd0, wr_count}, m_wr);
        check({tag, "_rd_count"}, {24'd0, rd_count}, m_rd);
    endtask

    // Monitor: samples 1 time unit after each active edge.
    initial begin
        exp_t e;
        int   got;
        forever begin
            @(posedge clk);
            #1;
            if (mon_on) begin
                check("mutex", {29'd0, 3'(int'(rvalid) + int'(wack) + int'(err))} <= 32'd1, 32'd1);
                if (rvalid || wack || err) begin
                    got = rvalid ? 0 : (wack ? 1 : 2);
                    if (sb.size() == 0) begin
                        check("unexpected_pulse", got, 32'hFF);
                    end else begin
                        e = sb.pop_front();
                        check("resp_kind", got, e.kind);
                        check("resp_latency", cyc, e.due);
                        if (e.kind == 0) begin
                            check("rdata", {24'd0, rdata}, {24'd0, e.data});
                            exp_last = e.data;
                        end
                    end
                end else begin
                    check("rdata_hold", {24'd0, rdata}, {24'd0, exp_last});
                    if (sb.size() > 0 && sb[0].due <= cyc) begin
                        e = sb.pop_front();
                        check("missing_resp", 32'hFF, e.kind);
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        wr    = 1'b0;
        addr  = 6'd0;
        wdata = 8'h00;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_rdata",    {24'd0, rdata},    0);
        check("rst_rvalid",   {31'd0, rvalid},   0);
        check("rst_wack",     {31'd0, wack},     0);
        check("rst_err",      {31'd0, err},      0);
        check("rst_wr_count", {24'd0, wr_count}, 0);
        check("rst_rd_count", {24'd0, rd_count}, 0);
        rst_n  = 1'b1;
        mon_on = 1'b1;

        // Write-then-read, back-to-back
        access(1'b1, 6'd12, 8'hA5);
        access(1'b1, 6'd14, 8'h3C);
        access(1'b0, 6'd12, 8'h00);
        access(1'b0, 6'd14, 8'h00);
        idle(3);
        check_counts("wtr");
        check("wtr_wr_count_2", {24'd0, wr_count}, 2);
        check("wtr_rd_count_2", {24'd0, rd_count}, 2);

        // Protected write then read of the protected word
        access(1'b1, 6'd56, 8'hFF);
        access(1'b0, 6'd56, 8'h00);
        idle(3);
        check_counts("prot");

        // Boundary, read-after-write forwarding, top address
        access(1'b1, 6'd55, 8'h11);
        access(1'b0, 6'd55, 8'h00);
        access(1'b1, 6'd48, 8'h22);
        access(1'b1, 6'd56, 8'h33);
        access(1'b0, 6'd48, 8'h00);
        access(1'b1, 6'd63, 8'h44);
        access(1'b0, 6'd63, 8'h00);
        access(1'b0, 6'd56, 8'h00);
        access(1'b1, 6'd23, 8'h5A);
        access(1'b0, 6'd23, 8'h00);
        idle(3);
        check_counts("bound");

        // Idle with toggling controls: no pulses, counters and rdata stable
        idle(10);
        check_counts("idle");

        // Write-counter saturation
        for (int i = 0; i < 260; i++) access(1'b1, 6'd0, 8'(i));
        idle(3);
        check_counts("sat");
        check("sat_wr_count_255", {24'd0, wr_count}, 255);
        access(1'b1, 6'd1, 8'h77);
        access(1'b0, 6'd0, 8'h00);
        idle(3);
        check_counts("sat_hold");

        // Reset mid-stream: pending read is dropped, access during reset discarded
        @(negedge clk);
        en = 1'b1; wr = 1'b0; addr = 6'd23; wdata = 8'h00;
        @(negedge clk);
        rst_n = 1'b0;
        en = 1'b1; wr = 1'b1; addr = 6'd5; wdata = 8'h77;
        model_reset();
        @(negedge clk);
        check("mid_rst_rdata",    {24'd0, rdata},    0);
        check("mid_rst_rvalid",   {31'd0, rvalid},   0);
        check("mid_rst_wack",     {31'd0, wack},     0);
        check("mid_rst_err",      {31'd0, err},      0);
        check("mid_rst_wr_count", {24'd0, wr_count}, 0);
        check("mid_rst_rd_count", {24'd0, rd_count}, 0);
        rst_n = 1'b1;
        drive(1'b0, 6'd23, 8'h00);
        access(1'b0, 6'd5, 8'h00);
        access(1'b0, 6'd12, 8'h00);
        idle(3);
        check_counts("post_rst");

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        mon_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
